mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory bus between an
// instruction-fetch port and a data port. The data port wins ties, but a
// saturating streak counter forces a fetch grant once the data port has
// been granted MAX_STREAK times in a row while a fetch was waiting.
module mem_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  // data port
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_stall,
  // shared memory bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // Streak counter must be able to hold 0..MAX_STREAK inclusive.
  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [2:0] {
    IDLE,
    BUS_IF,
    BUS_MEM,
    DONE_IF,
    DONE_MEM
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;

  logic          grant_if;
  logic          grant_mem;

  // Arbitration: data port first, unless the fetch has been starved long enough.
  always_comb begin
    grant_mem = mem_req && !(if_req && (streak_q == STREAK_MAX));
    grant_if  = if_req && !grant_mem;
  end

  // Next-state, streak bookkeeping and bus/readback register updates.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d     = BUS_MEM;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          // Only grants that make a fetch wait count toward the streak.
          if (if_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (grant_if) begin
          state_d    = BUS_IF;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr;
          streak_d   = '0;
        end
      end

      BUS_IF: begin
        // Bus fields stay frozen until the memory acknowledges.
        if (bus_ack) begin
          state_d    = DONE_IF;
          if_rdata_d = bus_rdata;
        end
      end

      BUS_MEM: begin
        if (bus_ack) begin
          state_d = DONE_MEM;
          // Stores leave the load-data register untouched.
          if (!bus_we_q) begin
            mem_rdata_d = bus_rdata;
          end
        end
      end

      // Completion cycles never look at requests, so a request still held
      // during its own ready pulse is only re-arbitrated from IDLE.
      DONE_IF:  state_d = IDLE;
      DONE_MEM: state_d = IDLE;

      default:  state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Outputs decoded from the registered state, plus combinational stalls.
  always_comb begin
    bus_req   = (state_q == BUS_IF) || (state_q == BUS_MEM);
    bus_we    = bus_we_q;
    bus_addr  = bus_addr_q;
    bus_wdata = bus_wdata_q;
    if_ready  = (state_q == DONE_IF);
    mem_ready = (state_q == DONE_MEM);
    if_rdata  = if_rdata_q;
    mem_rdata = mem_rdata_q;
    if_stall  = if_req && !if_ready;
    mem_stall = mem_req && !mem_ready;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random fetch/data traffic against a random-latency memory.
// A transaction-level reference model (timestamps, a streak count and the
// currently owned transfer) predicts every registered output cycle by cycle.
module tb_mem_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int N_CYCLES   = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .if_stall (if_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_stall(mem_stall),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model state
  bit          busy;          // a transfer owns the bus
  bit          owner_mem;     // owner of the current transfer
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  bit          t_we;
  int          free_cycle;    // first cycle the arbiter may grant again
  int          streak;        // data grants while a fetch was waiting
  bit          fresh;         // no grant since the last reset
  bit          e_bus_req;
  bit          e_if_ready;
  bit          e_mem_ready;
  logic [31:0] e_if_rdata;
  logic [31:0] e_mem_rdata;
  bit          pick_if;
  int          req_pct;
  int          n_txn;

  initial begin
    busy = 0; owner_mem = 0; t_addr = '0; t_wdata = '0; t_we = 0;
    free_cycle = 0; streak = 0; fresh = 1; n_txn = 0;
    e_bus_req = 0; e_if_ready = 0; e_mem_ready = 0;
    e_if_rdata = '0; e_mem_rdata = '0;

    for (int k = 0; k < N_CYCLES; k++) begin
      @(posedge clk);
      #1;
      // Registered outputs for cycle k
      check_eq("bus_req",   {31'b0, bus_req},   {31'b0, e_bus_req});
      check_eq("if_ready",  {31'b0, if_ready},  {31'b0, e_if_ready});
      check_eq("mem_ready", {31'b0, mem_ready}, {31'b0, e_mem_ready});
      check_eq("if_rdata",  if_rdata,  e_if_rdata);
      check_eq("mem_rdata", mem_rdata, e_mem_rdata);
      if (e_bus_req) begin
        check_eq("bus_addr", bus_addr, t_addr);
        check_eq("bus_we",   {31'b0, bus_we}, {31'b0, t_we});
        if (owner_mem) check_eq("bus_wdata", bus_wdata, t_wdata);
      end
      if (fresh) begin
        check_eq("rst_bus_addr",  bus_addr,  32'h0);
        check_eq("rst_bus_we",    {31'b0, bus_we}, 32'h0);
        check_eq("rst_bus_wdata", bus_wdata, 32'h0);
      end

      // Inputs for cycle k; traffic intensity alternates between phases
      req_pct = ((k / 400) % 2 == 0) ? 90 : 30;
      rst = (k < 3) || ($urandom_range(0, 99) < 2);

      if (if_req) begin
        if (e_if_ready && ($urandom_range(0, 99) >= req_pct)) if_req = 1'b0;
      end else if ($urandom_range(0, 99) < req_pct) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end

      if (mem_req) begin
        if (e_mem_ready && ($urandom_range(0, 99) >= req_pct)) mem_req = 1'b0;
      end else if ($urandom_range(0, 99) < req_pct) begin
        mem_req   = 1'b1;
        mem_we    = $urandom_range(0, 1) == 1;
        mem_addr  = $urandom & 32'hFFFF_FFFC;
        mem_wdata = $urandom;
      end

      bus_ack   = e_bus_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      bus_rdata = $urandom;
      #1;
      check_eq("if_stall",  {31'b0, if_stall},  {31'b0, (if_req && !e_if_ready)});
      check_eq("mem_stall", {31'b0, mem_stall}, {31'b0, (mem_req && !e_mem_ready)});

      // Predict the registered outputs of cycle k+1
      e_if_ready  = 0;
      e_mem_ready = 0;
      if (rst) begin
        busy = 0; streak = 0; fresh = 1;
        e_if_rdata = '0; e_mem_rdata = '0;
        free_cycle = k + 1;
      end else if (busy) begin
        if (bus_ack) begin
          busy = 0;
          free_cycle = k + 2;
          n_txn++;
          if (!owner_mem) begin
            e_if_ready = 1;
            e_if_rdata = bus_rdata;
            $display("txn %0d @%0d: IF  addr=%h rdata=%h", n_txn, k + 1, t_addr, bus_rdata);
          end else begin
            e_mem_ready = 1;
            if (!t_we) e_mem_rdata = bus_rdata;
            $display("txn %0d @%0d: MEM %s addr=%h data=%h", n_txn, k + 1,
                     t_we ? "WR" : "RD", t_addr, t_we ? t_wdata : bus_rdata);
          end
        end
      end else if (k >= free_cycle && (if_req || mem_req)) begin
        pick_if = if_req && (!mem_req || streak == MAX_STREAK);
        if (pick_if) begin
          streak    = 0;
          owner_mem = 0;
          t_addr    = if_addr;
          t_we      = 0;
        end else begin
          if (if_req && streak < MAX_STREAK) streak++;
          owner_mem = 1;
          t_addr    = mem_addr;
          t_we      = mem_we;
          t_wdata   = mem_wdata;
        end
        busy  = 1;
        fresh = 0;
      end
      e_bus_req = busy;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
